// File: rtl/mod_seq_ctrl_pkg.sv
// Shared types and constants for the repeated-subtraction modulo sequencer.
package mod_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_SUB  = 1'b1;

endpackage

// File: rtl/mod_iter_cnt.sv
// Iteration counter with synchronous clear/enable and an all-ones terminal flag.
module mod_iter_cnt #(
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              term_o
);

  logic [ITER_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + ITER_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = &cnt_q;

endmodule

// File: rtl/mod_seq_ctrl.sv
// Sequencer for the repeated-subtraction modulo datapath: latches operands,
// steps load/subtract, counts the quotient and flags div-by-zero or runaway.
module mod_seq_ctrl
  import mod_seq_ctrl_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned ITER_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      dividend,
  input  logic [W-1:0]      divisor,
  input  logic              x,
  input  logic [W-1:0]      temp,
  output logic [W-1:0]      op_a,
  output logic [W-1:0]      op_b,
  output logic              s,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      result,
  output logic [ITER_W-1:0] quotient,
  output logic              err_div0,
  output logic              err_timeout
);

  state_e              state_q, state_d;
  logic [W-1:0]        op_a_q, op_b_q, result_q;
  logic [ITER_W-1:0]   quotient_q;
  logic                busy_q, done_q, err_div0_q, err_timeout_q;
  logic                accept, div0, capture, timeout;
  logic                cnt_clr, cnt_en, cnt_term;
  logic [ITER_W-1:0]   cnt;

  mod_iter_cnt #(.ITER_W(ITER_W)) u_iter_cnt (
    .clk_i  (CLK),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  // s/we stay decoded from state because in SUB they depend on the live x.
  always_comb begin
    state_d = state_q;
    s       = SEL_LOAD;
    we      = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    accept  = 1'b0;
    div0    = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            accept  = 1'b1;
            cnt_clr = 1'b1;
            state_d = LOAD;
          end else begin
            div0    = 1'b1;
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        we      = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        if (x) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (cnt_term) begin
          timeout = 1'b1;
          state_d = ERR;
        end else begin
          s      = SEL_SUB;
          we     = 1'b1;
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        s       = SEL_SUB;
        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
      quotient_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_div0_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == LOAD) || (state_d == SUB);
      done_q  <= (state_d == DONE);
      if (accept) begin
        op_a_q        <= dividend;
        op_b_q        <= divisor;
        err_div0_q    <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      if (div0) begin
        err_div0_q    <= 1'b1;
        err_timeout_q <= 1'b0;
      end
      if (timeout) begin
        err_timeout_q <= 1'b1;
      end
      if (capture) begin
        result_q   <= temp;
        quotient_q <= cnt;
      end
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign result      = result_q;
  assign quotient    = quotient_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_div0    = err_div0_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Bench for mod_seq_ctrl with a behavioural subtract datapath and a
// quotient/remainder reference model.
module tb_mod_seq_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned IW   = 4;
  localparam int unsigned MAXQ = (1 << IW) - 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          x;
  logic [W-1:0]  temp = '0;
  logic [W-1:0]  op_a, op_b, result;
  logic          s, we, busy, done, err_div0, err_timeout;
  logic [IW-1:0] quotient;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  m_r = '0, m_opa = '0, m_opb = '0;
  logic [IW-1:0] m_q = '0;

  mod_seq_ctrl #(.W(W), .ITER_W(IW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .x(x), .temp(temp), .op_a(op_a), .op_b(op_b), .s(s), .we(we), .busy(busy),
    .done(done), .result(result), .quotient(quotient), .err_div0(err_div0),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  // Modulo datapath: temp register, subtractor and comparator.
  always @(posedge CLK) if (we) temp <= s ? temp - op_b : op_a;
  assign x = temp < op_b;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    tick; tick;
    n_cmp++;
    if ({op_a, op_b, result, 4'(quotient)} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got op_a=%0d op_b=%0d r=%0d q=%0d want all 0", op_a, op_b, result, quotient);
    end
    n_cmp++;
    if ({busy, done, we, s, err_div0, err_timeout} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/done/we/s/e0/et=%b want 000000", {busy, done, we, s, err_div0, err_timeout});
    end
    start = 1'b0; reset = 1'b1;
    tick;
    n_cmp++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b we=%b want 0 0", busy, we);
    end
    m_r = '0; m_q = '0; m_opa = '0; m_opb = '0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned qf;
    bit is_div0, is_to;
    int done_k, err_k, we_n, busy_n, done_n;
    int e_done_k, e_err_k, e_we_n, e_busy_n, e_done_n;
    logic s_done;
    is_div0 = (b == '0);
    qf      = is_div0 ? 0 : 32'(a) / 32'(b);
    is_to   = !is_div0 && (qf > MAXQ);
    start = 1'b1; dividend = a; divisor = b;
    tick;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    done_k = -1; err_k = -1; we_n = 0; busy_n = 0; done_n = 0; s_done = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      if (k == 1) begin
        n_cmp++;
        if (err_div0 !== is_div0 || err_timeout !== 1'b0) begin
          n_bad++;
          $display("FAIL flags_k1 a=%0d b=%0d: got e0=%b et=%b want %b 0", a, b, err_div0, err_timeout, is_div0);
        end
      end
      if (done) begin
        done_n++;
        if (done_k < 0) begin done_k = k; s_done = s; end
      end
      if ((err_div0 || err_timeout) && err_k < 0) err_k = k;
      if (we) we_n++;
      if (busy) busy_n++;
      tick;
    end
    if (is_div0) begin
      e_done_k = -1; e_err_k = 1; e_we_n = 0; e_busy_n = 0; e_done_n = 0;
    end else if (is_to) begin
      e_done_k = -1; e_err_k = 3 + int'(MAXQ); e_we_n = 1 + int'(MAXQ);
      e_busy_n = 2 + int'(MAXQ); e_done_n = 0;
      m_opa = a; m_opb = b;
    end else begin
      e_done_k = 3 + int'(qf); e_err_k = -1; e_we_n = 1 + int'(qf);
      e_busy_n = 2 + int'(qf); e_done_n = 1;
      m_opa = a; m_opb = b; m_r = a % b; m_q = IW'(qf);
    end
    n_cmp++;
    if (done_k != e_done_k || done_n != e_done_n) begin
      n_bad++;
      $display("FAIL done_timing a=%0d b=%0d: got k=%0d n=%0d want k=%0d n=%0d", a, b, done_k, done_n, e_done_k, e_done_n);
    end
    n_cmp++;
    if (err_k != e_err_k) begin
      n_bad++;
      $display("FAIL err_timing a=%0d b=%0d: got k=%0d want k=%0d", a, b, err_k, e_err_k);
    end
    n_cmp++;
    if (we_n != e_we_n || busy_n != e_busy_n) begin
      n_bad++;
      $display("FAIL we_busy a=%0d b=%0d: got we=%0d busy=%0d want we=%0d busy=%0d", a, b, we_n, busy_n, e_we_n, e_busy_n);
    end
    n_cmp++;
    if (result !== m_r || quotient !== m_q) begin
      n_bad++;
      $display("FAIL result a=%0d b=%0d: got r=%0d q=%0d want r=%0d q=%0d", a, b, result, quotient, m_r, m_q);
    end
    n_cmp++;
    if (op_a !== m_opa || op_b !== m_opb) begin
      n_bad++;
      $display("FAIL operands a=%0d b=%0d: got %0d/%0d want %0d/%0d", a, b, op_a, op_b, m_opa, m_opb);
    end
    n_cmp++;
    if (err_div0 !== is_div0 || err_timeout !== is_to) begin
      n_bad++;
      $display("FAIL err_final a=%0d b=%0d: got e0=%b et=%b want %b %b", a, b, err_div0, err_timeout, is_div0, is_to);
    end
    if (e_done_n == 1) begin
      n_cmp++;
      if (s_done !== 1'b1) begin
        n_bad++;
        $display("FAIL s_in_done a=%0d b=%0d: got %b want 1", a, b, s_done);
      end
    end
  endtask

  task automatic test_directed;
    run_op(8'd10, 8'd3);
    run_op(8'd2, 8'd5);
    run_op(8'd7, 8'd7);
    run_op(8'd0, 8'd7);
    run_op(8'd5, 8'd0);
    run_op(8'd9, 8'd4);
    run_op(8'd200, 8'd1);
    run_op(8'd9, 8'd4);
    run_op(8'd225, 8'd15);
    run_op(8'd240, 8'd15);
    run_op(8'd255, 8'd255);
  endtask

  task automatic test_back_to_back;
    int dk[$];
    logic bz [1:16];
    logic [W-1:0] r1;
    logic [IW-1:0] q1;
    int busy_n;
    r1 = '0; q1 = '0;
    start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    tick;
    dividend = 8'd9; divisor = 8'd4;
    for (int k = 1; k <= 16; k++) begin
      bz[k] = busy;
      if (done) begin
        dk.push_back(k);
        if (dk.size() == 1) begin r1 = result; q1 = quotient; end
      end
      if (k == 8) start = 1'b0;
      tick;
    end
    busy_n = 0;
    for (int k = 1; k <= 7; k++) if (bz[k]) busy_n++;
    n_cmp++;
    if (dk.size() != 2 || dk[0] != 6 || dk[1] != 12) begin
      n_bad++;
      $display("FAIL b2b_done: got %0d pulses first=%0d want 2 pulses at 6,12", dk.size(), (dk.size() > 0) ? dk[0] : -1);
    end
    n_cmp++;
    if (busy_n != 5 || bz[7] !== 1'b0 || bz[8] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy: got n=%0d b7=%b b8=%b want 5 0 1", busy_n, bz[7], bz[8]);
    end
    n_cmp++;
    if (r1 !== 8'd1 || q1 !== 4'd3) begin
      n_bad++;
      $display("FAIL b2b_first: got r=%0d q=%0d want 1 3", r1, q1);
    end
    n_cmp++;
    if (result !== 8'd1 || quotient !== 4'd2 || op_a !== 8'd9 || op_b !== 8'd4) begin
      n_bad++;
      $display("FAIL b2b_second: got r=%0d q=%0d a=%0d b=%0d want 1 2 9 4", result, quotient, op_a, op_b);
    end
    m_r = 8'd1; m_q = 4'd2; m_opa = 8'd9; m_opb = 8'd4;
  endtask

  task automatic test_reset_mid;
    start = 1'b1; dividend = 8'd200; divisor = 8'd1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy_before: got %b want 1", busy);
    end
    reset = 1'b0;
    tick;
    n_cmp++;
    if ({busy, done, we, s, err_div0, err_timeout} !== 6'b0 ||
        {op_a, op_b, result, 4'(quotient)} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got ctrl=%b a=%0d b=%0d r=%0d q=%0d want all 0",
               {busy, done, we, s, err_div0, err_timeout}, op_a, op_b, result, quotient);
    end
    reset = 1'b1;
    tick;
    n_cmp++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_release: got busy=%b we=%b want 0 0", busy, we);
    end
    m_r = '0; m_q = '0; m_opa = '0; m_opb = '0;
    run_op(8'd9, 8'd4);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    int unsigned r;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      if (r == 0) b = '0;
      else if (r < 3) b = W'($urandom_range(1, 4));
      else b = W'($urandom_range(1, 255));
      run_op(a, b);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want bench end");
    $fatal(1, "watchdog expired");
  end

endmodule
